// File: rtl/ece593w26_mac_pkg.sv
// Shared types and helpers for the MAC controller: FSM state encoding,
// requester count and a width-generic saturating adder.
package ece593w26_mac_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } mac_state_t;

  localparam int NREQ  = 2;
  localparam int SAT_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // Operands must already be sign-extended values that fit in w bits (w < SAT_W),
  // so the 64-bit sum itself can never wrap.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int                      w);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    s     = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = 1'b0;
    r.val = s;
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/ece593w26_rr_arb2.sv
// Two-way round-robin arbiter; the most recently granted requester loses ties.
module ece593w26_rr_arb2
  import ece593w26_mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  // requester that wins the next tie
  logic prio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (update && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ece593w26_mac_ctrl.sv
// Shares one sequential Booth multiplier between two requesters and folds each
// product into a per-requester saturating accumulator.
//
// state   | meaning
// IDLE    | arbitrate, accept one request, multiplier held in reset
// LOAD    | multiplier reset asserted so it loads x
// RUN     | multiplier running for MUL_LAT cycles (down-counter)
// CAPTURE | sample product, update accumulator and response registers
// RESP    | response presented until rsp_ready
module ece593w26_mac_ctrl
  import ece593w26_mac_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 18,
  parameter int ACC_W   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][WIDTH-1:0] req_w,
  input  logic [1:0][WIDTH-1:0] req_x,
  input  logic [1:0]            req_acc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [ACC_W-1:0]      rsp_data,
  output logic                  rsp_ovf,
  output logic                  mul_rst,
  output logic [WIDTH-1:0]      mul_w,
  output logic [WIDTH-1:0]      mul_x,
  input  logic [2*WIDTH:0]      mul_f
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  mac_state_t              state;
  mac_state_t              state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [1:0]              grant;
  logic                    accept;
  logic                    acc_mode;
  logic                    op_id;
  logic [ACC_W-1:0]        acc [NREQ];
  logic [NREQ-1:0]         ovf;
  logic signed [SAT_W-1:0] acc_ext;
  logic signed [SAT_W-1:0] prod_ext;
  sat_res_t                sum;
  logic                    ovf_nxt;
  logic                    unused_bits;

  ece593w26_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    mul_rst   = 1'b1;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          req_ready = grant & req_valid;
        end
        if (!rst && ((grant & req_valid) != 2'b00)) begin
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        mul_rst = 1'b0;
        if (cnt == '0) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        mul_rst   = 1'b0;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit 2*WIDTH of mul_f is not part of the product
  assign acc_ext  = acc_mode ? SAT_W'(signed'(acc[op_id])) : '0;
  assign prod_ext = SAT_W'(signed'(mul_f[2*WIDTH-1:0]));
  assign sum      = sat_add(acc_ext, prod_ext, ACC_W);
  assign ovf_nxt  = (acc_mode & ovf[op_id]) | sum.ovf;

  assign unused_bits = ^{mul_f[2*WIDTH], sum.val[SAT_W-1:ACC_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_w    <= '0;
      mul_x    <= '0;
      acc_mode <= 1'b0;
      op_id    <= 1'b0;
      cnt      <= '0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      ovf      <= '0;
      for (int i = 0; i < NREQ; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (accept) begin
        mul_w    <= req_w[grant[1]];
        mul_x    <= req_x[grant[1]];
        acc_mode <= req_acc[grant[1]];
        op_id    <= grant[1];
      end
      if (state == LOAD) begin
        cnt <= CNT_W'(MUL_LAT - 1);
      end else if ((state == RUN) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == CAPTURE) begin
        acc[op_id] <= sum.val[ACC_W-1:0];
        ovf[op_id] <= ovf_nxt;
        rsp_id     <= op_id;
        rsp_data   <= sum.val[ACC_W-1:0];
        rsp_ovf    <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ece593w26_mac_ctrl.sv
// Scoreboard bench for the MAC controller: two instances (ACC_W 24 and 17)
// each driven through a behavioural sequential multiplier model.
module tb_ece593w26_mac_ctrl;

  localparam int WIDTH   = 8;
  localparam int MUL_LAT = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            req_valid = 2'b00;
  logic [1:0]            req_acc   = 2'b00;
  logic [1:0][WIDTH-1:0] req_w     = '0;
  logic [1:0][WIDTH-1:0] req_x     = '0;
  logic                  rsp_ready = 1'b1;

  logic [1:0]  rdy_a, rdy_b;
  logic        rv_a, rv_b, rid_a, rid_b, rovf_a, rovf_b;
  logic [23:0] rdata_a;
  logic [16:0] rdata_b;
  logic        mrst [2];
  logic [7:0]  mw [2];
  logic [7:0]  mx [2];
  logic [16:0] mf [2];
  int          mcnt [2];

  logic [1:0]  rdy;
  logic        rv, rid, rovf, mrst_m;
  logic [23:0] rdata;
  logic [7:0]  mw_m, mx_m;

  ece593w26_mac_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .ACC_W(24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(sel ? 2'b00 : req_valid), .req_ready(rdy_a),
    .req_w(req_w), .req_x(req_x), .req_acc(req_acc),
    .rsp_valid(rv_a), .rsp_ready(sel ? 1'b1 : rsp_ready),
    .rsp_id(rid_a), .rsp_data(rdata_a), .rsp_ovf(rovf_a),
    .mul_rst(mrst[0]), .mul_w(mw[0]), .mul_x(mx[0]), .mul_f(mf[0])
  );

  ece593w26_mac_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .ACC_W(17)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(sel ? req_valid : 2'b00), .req_ready(rdy_b),
    .req_w(req_w), .req_x(req_x), .req_acc(req_acc),
    .rsp_valid(rv_b), .rsp_ready(sel ? rsp_ready : 1'b1),
    .rsp_id(rid_b), .rsp_data(rdata_b), .rsp_ovf(rovf_b),
    .mul_rst(mrst[1]), .mul_w(mw[1]), .mul_x(mx[1]), .mul_f(mf[1])
  );

  assign rdy    = sel ? rdy_b : rdy_a;
  assign rv     = sel ? rv_b : rv_a;
  assign rid    = sel ? rid_b : rid_a;
  assign rovf   = sel ? rovf_b : rovf_a;
  assign rdata  = sel ? {{7{rdata_b[16]}}, rdata_b} : rdata_a;
  assign mrst_m = sel ? mrst[1] : mrst[0];
  assign mw_m   = sel ? mw[1] : mw[0];
  assign mx_m   = sel ? mx[1] : mx[0];

  function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // product is valid only after exactly MUL_LAT edges out of reset; junk otherwise
  for (genvar g = 0; g < 2; g++) begin : g_mul
    always @(posedge clk) begin
      if (mrst[g]) begin
        mcnt[g] <= 0;
        mf[g]   <= 17'h12345;
      end else begin
        mcnt[g] <= mcnt[g] + 1;
        if (mcnt[g] + 1 == MUL_LAT) mf[g] <= {1'b1, mul16(mw[g], mx[g])};
        else                        mf[g] <= 17'h16A5C ^ 17'(mcnt[g]);
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int     id;
    longint data;
    int     ovf;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  longint macc [2][2];
  int     movf [2][2];

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 2; i++) begin
        macc[d][i] = 0;
        movf[d][i] = 0;
      end
  endtask

  task automatic push_exp(input int id, input logic [7:0] w, input logic [7:0] x, input logic acc);
    longint p, s, hi, lo;
    int     aw, ov, d;
    exp_t   e;
    d  = sel ? 1 : 0;
    aw = sel ? 17 : 24;
    hi = (64'sd1 <<< (aw - 1)) - 1;
    lo = -hi - 1;
    p  = longint'($signed(w)) * longint'($signed(x));
    s  = acc ? macc[d][id] + p : p;
    ov = acc ? movf[d][id] : 0;
    if (s > hi) begin s = hi; ov = 1; end
    else if (s < lo) begin s = lo; ov = 1; end
    macc[d][id] = s;
    movf[d][id] = ov;
    e.id = id; e.data = s; e.ovf = ov;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && rv && rsp_ready) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("rsp_id", rid, mon_e.id);
        chk("rsp_data", $signed(rdata), mon_e.data);
        chk("rsp_ovf", rovf, mon_e.ovf);
      end
    end
  end

  task automatic do_op(input int id, input logic [7:0] w, input logic [7:0] x, input logic acc);
    int n, low;
    bit got;
    @(posedge clk); #1;
    req_w[id] = w; req_x[id] = x; req_acc[id] = acc; req_valid[id] = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rdy[id]) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      req_valid[id] = 1'b0;
      return;
    end
    push_exp(id, w, x, acc);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    n = 0; low = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (!mrst_m) low++;
      if (rv) got = 1;
    end
    chk("rsp_latency", n, MUL_LAT + 3);
    chk("mul_rst_low", low, MUL_LAT + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int k;
    bit got;
    clear_model();
    #2 rst = 1'b1;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", rdy, 0);
    chk("reset_mul_rst", mrst_m, 1);
    chk("reset_rsp_valid", rv, 0);
    chk("reset_rsp_data", rdata, 0);
    chk("reset_rsp_id", rid, 0);
    chk("reset_rsp_ovf", rovf, 0);
    chk("reset_mul_w", mw_m, 0);
    chk("reset_mul_x", mx_m, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;

    // single op and accumulation
    do_op(0, 8'd3, 8'hFB, 1'b0);
    do_op(0, 8'd7, 8'd6, 1'b1);
    do_op(1, 8'h80, 8'h80, 1'b1);
    do_op(0, 8'd1, 8'd1, 1'b1);
    drain();

    // contention with both requesters held valid
    do_reset();
    req_w[0] = 8'd2; req_x[0] = 8'd3; req_w[1] = 8'hFC; req_x[1] = 8'd5; req_acc = 2'b11;
    req_valid = 2'b11;
    k = 0;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (rdy != 2'b00) begin
        chk("ready_onehot", $countones(rdy), 1);
        chk("grant_order", rdy[1], k % 2);
        push_exp(int'(rdy[1]), req_w[rdy[1]], req_x[rdy[1]], 1'b1);
        k++;
      end
    end
    chk("contention_grants", k, 4);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // backpressure
    rsp_ready = 1'b0;
    do_op(1, 8'd10, 8'd10, 1'b0);
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data", $signed(rdata), 100);
      chk("bp_ready", rdy, 0);
      chk("bp_valid", rv, 1);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // reset while RUN
    @(posedge clk); #1;
    req_w[0] = 8'd5; req_x[0] = 8'd5; req_acc[0] = 1'b1; req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (rdy[0]) got = 1;
    end
    chk("midrst_accept", got, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    req_valid[0] = 1'b1;
    clear_model();
    #1;
    chk("midrst_mul_rst", mrst_m, 1);
    chk("midrst_rsp_valid", rv, 0);
    chk("midrst_req_ready", rdy, 0);
    chk("midrst_rsp_data", rdata, 0);
    chk("midrst_rsp_id", rid, 0);
    chk("midrst_mul_w", mw_m, 0);
    chk("midrst_mul_x", mx_m, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req_valid[0] = 1'b0;
    repeat (30) @(negedge clk);
    do_op(0, 8'd2, 8'd2, 1'b1);
    drain();

    // saturation on the ACC_W=17 instance
    sel = 1'b1;
    do_reset();
    do_op(0, 8'h80, 8'h80, 1'b0);
    do_op(0, 8'h80, 8'h80, 1'b1);
    do_op(0, 8'h80, 8'h80, 1'b1);
    do_op(0, 8'h80, 8'h80, 1'b1);
    do_op(0, 8'd1, 8'd1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
